// File: rtl/fpadd_pkg.sv
// Shared constants for the streaming FP-adder controller and its result FIFO.
package fpadd_pkg;
    localparam int FP_W          = 32;
    localparam int FPADD_LATENCY = 2;
    localparam int RESULT_DEPTH  = 4;
endpackage

// File: rtl/fp_result_fifo.sv
// Single-clock result FIFO. The producer never pushes into a full FIFO
// because the controller only issues against free credits; the push guard
// below is a backstop, not the flow-control mechanism.
module fp_result_fifo
    import fpadd_pkg::*;
#(
    parameter int W     = FP_W,
    parameter int DEPTH = RESULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Qualify requests against the current occupancy.
    always_comb begin
        do_push = push && (count_q < (AW+1)'(DEPTH));
        do_pop  = pop && (count_q != '0);
        empty   = (count_q == '0);
        head    = mem[rd_ptr];
        count   = count_q;
    end

    // Storage array; written at the write pointer, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/fpadd_stream_ctrl.sv
// Streaming controller around a fixed-latency, non-stallable FP adder.
// Operands are registered into the adder, a valid shift register tracks
// sums in flight, and returning sums land in a small result FIFO.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on registered state (credits), so the
// producer may hold in_valid while waiting. out_valid never drops without a
// pop, and out_data is stable while out_valid is high and out_ready is low.
module fpadd_stream_ctrl
    import fpadd_pkg::*;
#(
    parameter int LATENCY = FPADD_LATENCY,
    parameter int DEPTH   = RESULT_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_A,
    input  logic [FP_W-1:0] in_B,
    output logic [FP_W-1:0] add_A,
    output logic [FP_W-1:0] add_B,
    input  logic [FP_W-1:0] add_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_data,
    output logic            busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               run_q;
    logic [LATENCY-1:0] vpipe;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [31:0]        inflight;
    logic [31:0]        occupancy;
    logic               issue;
    logic               push;
    logic               pop;

    // Credit check: sums in flight plus buffered sums must leave room, so
    // every returning sum is guaranteed a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + {31'b0, vpipe[i]};
        end
        occupancy = inflight + {{(32-CW){1'b0}}, fifo_count};
        in_ready  = run_q && (occupancy < 32'(DEPTH));
        issue     = in_valid && in_ready;
        push      = vpipe[LATENCY-1];
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        busy      = (|vpipe) || !fifo_empty;
    end

    // run_q holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Operand registers feeding the adder; they hold between issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_A <= '0;
            add_B <= '0;
        end else if (issue) begin
            add_A <= in_A;
            add_B <= in_B;
        end
    end

    if (LATENCY == 1) begin : g_lat1
        // Single-stage valid tracker.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vpipe <= '0;
            end else begin
                vpipe <= issue;
            end
        end
    end else begin : g_latn
        // Valid tracker shifts every cycle because the adder never stalls.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vpipe <= '0;
            end else begin
                vpipe <= {vpipe[LATENCY-2:0], issue};
            end
        end
    end

    fp_result_fifo #(
        .W     (FP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (add_out),
        .pop       (pop),
        .head      (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_fpadd_stream_ctrl.sv
// Bench for fpadd_stream_ctrl with a two-cycle adder model driven from
// add_A/add_B. Expected sums are hand-computed table entries.
module tb_fpadd_stream_ctrl;
    localparam int CYCLE = 20;
    localparam int LAT   = 2;
    localparam int NV    = 15;

    // Operand pairs and their IEEE-754 single sums (k + 1.0 for rows 1..12).
    localparam logic [31:0] TBL_A [NV] = '{
        32'h3f800000, 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000,
        32'h41200000, 32'h41300000, 32'h41400000, 32'h7f800000, 32'h00000000};
    localparam logic [31:0] TBL_B [NV] = '{
        32'h40000000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000,
        32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000,
        32'h3f800000, 32'h3f800000, 32'h3f800000, 32'hff800000, 32'h80000000};
    localparam logic [31:0] TBL_S [NV] = '{
        32'h40400000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
        32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000, 32'h41200000,
        32'h41300000, 32'h41400000, 32'h41500000, 32'h7fc00000, 32'h00000000};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [31:0] add_A;
    logic [31:0] add_B;
    logic [31:0] add_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    logic [31:0] exp_q[$];
    int          stream_cyc[$];
    int          n_cmp;
    int          n_err;
    int          cyc;
    int          stall_cnt;
    bit          stream_phase;

    fpadd_stream_ctrl #(.LATENCY(LAT), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .add_A     (add_A),
        .add_B     (add_B),
        .add_out   (add_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #(CYCLE/2) clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(CYCLE * 5000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- adder model ----------------
    function automatic logic [31:0] fp_lookup(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NV; i++) begin
            if (TBL_A[i] == a && TBL_B[i] == b) return TBL_S[i];
        end
        return 32'hdeadbeef;
    endfunction

    // Sum of the registered operands becomes visible LAT-1 edges after they
    // change, so the controller samples it on the edge LAT after issue.
    always @(posedge clk) add_out <= fp_lookup(add_A, add_B);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Offer pair idx; returns on the falling edge after the issue edge with
    // in_valid still high, so the caller either sends again or drops it.
    task automatic send(input int idx);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_A     = TBL_A[idx];
        in_B     = TBL_B[idx];
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1 for pair %0d", idx);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(TBL_S[idx]);
            @(posedge clk);
            @(negedge clk);
        end
        stall_cnt += waited;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk(name, {31'b0, busy}, 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got %h expected none", out_data);
                end else begin
                    chk("result", out_data, exp_q.pop_front());
                end
                if (stream_phase) stream_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bp_idx;
        bit acc;
        int seen;
        n_cmp = 0; n_err = 0; cyc = 0; stall_cnt = 0; stream_phase = 0;
        reset = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; out_ready = 1'b0;
        idle(3);

        // Reset values.
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_add_A", add_A, 32'd0);
        chk("rst_add_B", add_B, 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rel_in_ready_after_edge", {31'b0, in_ready}, 32'd1);

        // Single add; the issue edge counts as the first of LAT+1 edges.
        out_ready = 1'b1;
        send(0);
        in_valid = 1'b0;
        chk("single_add_A", add_A, 32'h3f800000);
        chk("single_add_B", add_B, 32'h40000000);
        for (int e = 1; e < LAT; e++) begin
            chk("single_early_valid", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        chk("single_early_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("single_valid_on_time", {31'b0, out_valid}, 32'd1);
        chk("single_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("single_busy_fall", {31'b0, busy}, 32'd0);
        chk("single_valid_fall", {31'b0, out_valid}, 32'd0);

        // Backpressure: six pairs offered with the consumer stalled.
        out_ready = 1'b0;
        bp_idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (bp_idx < 6);
            in_A = TBL_A[1 + bp_idx];
            in_B = TBL_B[1 + bp_idx];
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(TBL_S[1 + bp_idx]);
            @(posedge clk);
            @(negedge clk);
            if (acc) bp_idx++;
        end
        chk("bp_accepted", 32'(bp_idx), 32'd4);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && bp_idx < 6; c++) begin
            in_valid = 1'b1;
            in_A = TBL_A[1 + bp_idx];
            in_B = TBL_B[1 + bp_idx];
            acc = in_ready;
            if (acc) exp_q.push_back(TBL_S[1 + bp_idx]);
            @(posedge clk);
            @(negedge clk);
            if (acc) bp_idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 32'(bp_idx), 32'd6);
        wait_idle("bp_drain");

        // Streaming: 11 back-to-back pairs.
        stall_cnt = 0;
        stream_phase = 1'b1;
        for (int i = 2; i <= 12; i++) send(i);
        in_valid = 1'b0;
        wait_idle("stream_drain");
        stream_phase = 1'b0;
        chk("stream_stalls", 32'(stall_cnt), 32'd0);
        chk("stream_count", 32'(stream_cyc.size()), 32'd11);
        seen = 0;
        for (int i = 1; i < stream_cyc.size(); i++) begin
            if (stream_cyc[i] != stream_cyc[i-1] + 1) seen++;
        end
        chk("stream_gaps", 32'(seen), 32'd0);

        // Push and pop on the same edge with three entries buffered.
        out_ready = 1'b0;
        send(3); send(4); send(5);
        in_valid = 1'b0;
        idle(LAT + 1);
        chk("pp_three_buffered_ready", {31'b0, in_ready}, 32'd1);
        send(6);
        in_valid = 1'b0;
        chk("pp_full_credit", {31'b0, in_ready}, 32'd0);
        idle(LAT - 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pp_count_held", 32'(dut.u_fifo.count), 32'd3);
        chk("pp_ready_after", {31'b0, in_ready}, 32'd1);
        chk("pp_valid_after", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_idle("pp_drain");

        // Reset with one sum buffered and two in flight.
        out_ready = 1'b0;
        send(7);
        in_valid = 1'b0;
        idle(LAT + 1);
        send(8);
        send(9);
        in_valid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        idle(2);
        reset = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst_no_stale", 32'(seen), 32'd0);

        // Special encodings pass through bit-exact.
        send(13);
        send(14);
        in_valid = 1'b0;
        wait_idle("special_drain");

        idle(2);
        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpadd_stream_ctrl.md
FPADD_STREAM_CTRL -- requirements
Module: fpadd_stream_ctrl

Interface
REQ-001 Parameter LATENCY, default 2: cycles from a change on add_A/add_B to the matching sum on add_out in fpadd_pipelined.
REQ-002 Parameter DEPTH, default 4: result FIFO entries, a power of two of at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  operand pair accepted this cycle when high together with in_valid.
REQ-007 in_A  input  32  IEEE-754 single operand A.
REQ-008 in_B  input  32  IEEE-754 single operand B.
REQ-009 add_A  output  32  registered operand A, driving adder reg_A.
REQ-010 add_B  output  32  registered operand B, driving adder reg_B.
REQ-011 add_out  input  32  adder result, driven by adder out.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  32  oldest buffered sum.
REQ-015 busy  output  1  high while any issue is in flight or the FIFO is non-empty.

Function
REQ-016 Issue occurs when in_valid and in_ready are both high; add_A and add_B load in_A and in_B at that edge and hold their values on non-issue cycles.
REQ-017 A valid shift register of LATENCY bits shall set bit 0 on each issue edge and shift every cycle; the adder has no stall.
REQ-018 At each edge where the last valid bit is high, add_out shall be written into the result FIFO.
REQ-019 in_ready = (in-flight count + FIFO count) < DEPTH, so a sum never arrives at a full FIFO; the adder pipeline cannot be stalled.
REQ-020 in_ready is combinational from registered state only, with no path from in_valid or out_ready.
REQ-021 out_valid = FIFO non-empty; out_data = FIFO head; a pop occurs when out_valid and out_ready are both high.
REQ-022 Push and pop on the same edge: count unchanged, both pointers advance.
REQ-023 Pointers wrap modulo DEPTH; the count register is log2(DEPTH)+1 bits wide.
REQ-024 Results leave in issue order; the data path is bit-exact, with no FP interpretation.
REQ-025 Minimum latency from an issue edge to out_valid high is LATENCY+1 edges; sustained throughput is 1 pair per cycle while out_ready stays high.

Reset
REQ-026 While reset is low: add_A=0, add_B=0, valid pipe cleared, pointers and count=0, out_valid=0, busy=0, in_ready=0.
REQ-027 in_ready rises on the first edge after reset deasserts.
REQ-028 Reset mid-operation discards every in-flight and buffered result; add_out is ignored until new issues return.

Structure
REQ-029 Package fpadd_pkg holds FP_W=32, FPADD_LATENCY=2 and RESULT_DEPTH=4; the module defaults use these values.
REQ-030 The result FIFO is sub-module fp_result_fifo (synchronous, single clock, same reset); valid pipe and credit logic stay in fpadd_stream_ctrl.

Verification
REQ-031 The bench pairs the block with a LATENCY-cycle model of fpadd_pipelined; CYCLE=20 ns.
REQ-032 Single add: in_A=3f800000, in_B=40000000, out_ready=1 -> out_data=40400000 with out_valid high exactly LATENCY+1 edges after issue; busy then falls.
REQ-033 Backpressure: out_ready=0, offer 6 pairs -> exactly 4 accepted, in_ready low thereafter; raise out_ready -> 4 results in order, then the remaining 2 accepted.
REQ-034 Streaming: 11 back-to-back pairs with out_ready=1 -> 11 results on consecutive cycles, order preserved, in_ready never low.
REQ-035 Simultaneous push/pop with the FIFO at DEPTH-1 -> count holds and no entry is lost or duplicated across pointer wrap.
REQ-036 Reset asserted with 2 pairs in flight and 1 buffered -> out_valid=0 immediately; no stale result appears after release.
REQ-037 Specials: 7f800000+ff800000 -> 7fc00000 and 00000000+80000000 -> 00000000 passed through unchanged.
